// File: rtl/dac_ramp_envelope.sv
// Linear amplitude envelope for the composed DAC sample: 4-state ramp FSM plus a 2-stage multiply.
// Optional macro RAMP_ROUND_EN: round half up before the final shift (truncation toward -inf otherwise).
module dac_ramp_envelope #(
  parameter int FRAC_BITS  = 15,
  parameter int STEP_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [15:0]           signal_in,
  input  logic                  signal_in_valid,
  input  logic                  ramp_request,
  input  logic [STEP_WIDTH-1:0] ramp_step,
  output logic [15:0]           signal_out,
  output logic                  signal_valid,
  output logic [1:0]            ramp_state,
  output logic [FRAC_BITS:0]    ramp_factor
);

  typedef enum logic [1:0] {IDLE = 2'd0, UP = 2'd1, HOLD = 2'd2, DOWN = 2'd3} state_t;

  // Arithmetic width holds both the step and unity with headroom, so the sum never wraps.
  localparam int SW = ((STEP_WIDTH > FRAC_BITS) ? STEP_WIDTH : FRAC_BITS + 1) + 2;
  localparam int PW = 18 + FRAC_BITS;
  localparam logic [FRAC_BITS:0] UNITY_F = {1'b1, {FRAC_BITS{1'b0}}};
  localparam logic [SW-1:0]      UNITY   = {{(SW-FRAC_BITS-1){1'b0}}, UNITY_F};

  state_t                state_q;
  logic [FRAC_BITS:0]    factor_q;
  logic [SW-1:0]         step_w, fac_w, sum_w;
  logic [FRAC_BITS:0]    up_d, dn_d;

  // A zero step means "jump straight to the target"; treat it as a full-scale step.
  always_comb begin
    step_w = (ramp_step == '0) ? UNITY : SW'(ramp_step);
    fac_w  = {{(SW-FRAC_BITS-1){1'b0}}, factor_q};
    sum_w  = fac_w + step_w;
    up_d   = (sum_w >= UNITY) ? UNITY_F : sum_w[FRAC_BITS:0];
    dn_d   = (step_w >= fac_w) ? '0 : (factor_q - step_w[FRAC_BITS:0]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      factor_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (ramp_request) begin
            factor_q <= up_d;
            state_q  <= (up_d == UNITY_F) ? HOLD : UP;
          end else begin
            factor_q <= '0;
          end
        end
        UP, DOWN: begin
          if (ramp_request) begin
            factor_q <= up_d;
            state_q  <= (up_d == UNITY_F) ? HOLD : UP;
          end else begin
            factor_q <= dn_d;
            state_q  <= (dn_d == '0) ? IDLE : DOWN;
          end
        end
        HOLD: begin
          if (!ramp_request) begin
            factor_q <= dn_d;
            state_q  <= (dn_d == '0) ? IDLE : DOWN;
          end else begin
            factor_q <= UNITY_F;
          end
        end
        default: begin
          state_q  <= IDLE;
          factor_q <= '0;
        end
      endcase
    end
  end

  // Datapath: stage 1 multiplies by the factor registered this cycle, stage 2 rescales.
  logic signed [PW-1:0] a_ext, f_ext, prod_q, rnd_w;
  logic                 vld1_q, vld2_q;
  logic [15:0]          out_q;

  always_comb begin
    a_ext = {{(PW-16){signal_in[15]}}, signal_in};
    f_ext = {{(PW-FRAC_BITS-1){1'b0}}, factor_q};
`ifdef RAMP_ROUND_EN
    rnd_w = prod_q + {{(PW-FRAC_BITS){1'b0}}, 1'b1, {(FRAC_BITS-1){1'b0}}};
`else
    rnd_w = prod_q;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prod_q <= '0;
      vld1_q <= 1'b0;
      out_q  <= '0;
      vld2_q <= 1'b0;
    end else begin
      prod_q <= a_ext * f_ext;
      vld1_q <= signal_in_valid;
      out_q  <= 16'(rnd_w >>> FRAC_BITS);
      vld2_q <= vld1_q;
    end
  end

  assign signal_out   = out_q;
  assign signal_valid = vld2_q;
  assign ramp_state   = state_q;
  assign ramp_factor  = factor_q;

endmodule
